write_sink_fifo: RTL and testbench

- Receiving end of the write_enable/writedata interface; captures each accepted write word into a small synchronous FIFO.
- Presents the captured words to a downstream reader through a read_enable/readdata/readvalid port.
- Sits directly after any block that drives write_enable/writedata.
- Guarantees readdata is never X/Z, independent of read_enable, from the first clock after reset.

---
 rtl/write_sink_if.sv | 28 ++
 rtl/write_sink_fifo.sv | 117 +++++++++++
 tb/tb_write_sink_fifo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/write_sink_if.sv
// Write/read handshake bundle between a write source, write_sink_fifo and its downstream reader.
interface write_sink_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              write_enable;
  logic [DATA_W-1:0] writedata;
  logic              full;
  logic              read_enable;
  logic [DATA_W-1:0] readdata;
  logic              readvalid;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output write_enable, writedata, read_enable,
    input  full, readdata, readvalid, empty, count, overflow, underflow
  );

  modport slave (
    input  write_enable, writedata, read_enable,
    output full, readdata, readvalid, empty, count, overflow, underflow
  );
endinterface

// File: rtl/write_sink_fifo.sv
// Small synchronous FIFO capturing accepted write words for a downstream reader.
// Optional WRITE_SINK_XCHECK_EN adds an X/Z check on accepted-side writedata and an xerr output.
module write_sink_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic          clk,
  input  logic          rst,
  write_sink_if.slave   bus
`ifdef WRITE_SINK_XCHECK_EN
  ,
  output logic          xerr
`endif
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              readvalid_q, readvalid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_acc;
  logic              wr_acc;

  // A read frees a slot in the same cycle, so a write while full is taken when paired with a read.
  always_comb begin
    rd_acc      = bus.read_enable & ~empty_q;
    wr_acc      = bus.write_enable & (~full_q | rd_acc);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    readdata_d  = readdata_q;
    readvalid_d = 1'b0;
    overflow_d  = overflow_q | (bus.write_enable & ~wr_acc);
    underflow_d = underflow_q | (bus.read_enable & empty_q);

    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_acc) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      readdata_d  = mem_q[rd_ptr_q];
      readvalid_d = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == CNT_W'(0));
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      readdata_q  <= '0;
      readvalid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      readdata_q  <= readdata_d;
      readvalid_q <= readvalid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset; only accepted words are ever read out.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= bus.writedata;
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.readdata  = readdata_q;
  assign bus.readvalid = readvalid_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

`ifdef WRITE_SINK_XCHECK_EN
  logic xerr_q, xerr_d;
  logic x_in;

  always_comb begin
    x_in   = bus.write_enable && ((^bus.writedata) === 1'bx);
    xerr_d = xerr_q | x_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xerr_q <= 1'b0;
    end else begin
      xerr_q <= xerr_d;
      if (x_in) $error("write_sink_fifo: X/Z on writedata with write_enable at %0t", $time);
    end
  end

  assign xerr = xerr_q;
`endif
endmodule

// File: tb/tb_write_sink_fifo.sv
// Directed self-checking bench for write_sink_fifo (DATA_W=8, DEPTH=4).
module tb_write_sink_fifo;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  write_sink_if #(.DATA_W(8), .DEPTH(4)) bus ();

`ifdef WRITE_SINK_XCHECK_EN
  logic xerr;
  write_sink_fifo #(.DATA_W(8), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus), .xerr(xerr));
`else
  write_sink_fifo #(.DATA_W(8), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic we, input logic [7:0] wd, input logic re);
    bus.write_enable = we;
    bus.writedata    = wd;
    bus.read_enable  = re;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.write_enable = 1'b0;
    bus.writedata    = 8'h00;
    bus.read_enable  = 1'b0;
    rst = 1'b1;
    #1;
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    repeat (3) step(1'b0, 8'h00, 1'b0);

    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_readdata", 32'(bus.readdata), 32'h00);
    check("rst_readvalid", 32'(bus.readvalid), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_underflow", 32'(bus.underflow), 32'd0);

    step(1'b1, 8'hA1, 1'b0);
    check("first_write_count", 32'(bus.count), 32'd1);
    check("first_write_empty", 32'(bus.empty), 32'd0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'hD4, 1'b0);
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'd4);

    step(1'b1, 8'hEE, 1'b0);
    check("drop_overflow", 32'(bus.overflow), 32'd1);
    check("drop_count", 32'(bus.count), 32'd4);
    check("drop_readvalid", 32'(bus.readvalid), 32'd0);

    step(1'b1, 8'hEE, 1'b1);
    check("fullrw_readdata", 32'(bus.readdata), 32'hA1);
    check("fullrw_readvalid", 32'(bus.readvalid), 32'd1);
    check("fullrw_count", 32'(bus.count), 32'd4);
    check("fullrw_full", 32'(bus.full), 32'd1);

    step(1'b0, 8'h00, 1'b1);
    check("drain0_data", 32'(bus.readdata), 32'hB2);
    check("drain0_valid", 32'(bus.readvalid), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    check("drain1_data", 32'(bus.readdata), 32'hC3);
    step(1'b0, 8'h00, 1'b1);
    check("drain2_data", 32'(bus.readdata), 32'hD4);
    step(1'b0, 8'h00, 1'b1);
    check("drain3_data", 32'(bus.readdata), 32'hEE);
    check("drain3_valid", 32'(bus.readvalid), 32'd1);
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_count", 32'(bus.count), 32'd0);

    step(1'b0, 8'h00, 1'b0);
    check("idle_valid_drop", 32'(bus.readvalid), 32'd0);
    check("idle_data_hold", 32'(bus.readdata), 32'hEE);

    step(1'b0, 8'h00, 1'b1);
    check("udf_valid", 32'(bus.readvalid), 32'd0);
    check("udf_data_hold", 32'(bus.readdata), 32'hEE);
    check("udf_flag", 32'(bus.underflow), 32'd1);

    step(1'b1, 8'h55, 1'b1);
    check("emptyrw_count", 32'(bus.count), 32'd1);
    check("emptyrw_valid", 32'(bus.readvalid), 32'd0);
    check("emptyrw_data", 32'(bus.readdata), 32'hEE);
    step(1'b0, 8'h00, 1'b1);
    check("emptyrw_read", 32'(bus.readdata), 32'h55);
    check("emptyrw_read_valid", 32'(bus.readvalid), 32'd1);
    check("emptyrw_empty", 32'(bus.empty), 32'd1);

    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0);
      step(1'b0, 8'h00, 1'b1);
      check($sformatf("wrap_%0d", i), 32'(bus.readdata), 32'(8'h10 + i));
    end

    step(1'b1, 8'h61, 1'b0);
    step(1'b1, 8'h62, 1'b0);
    step(1'b1, 8'h63, 1'b0);
    check("pre_rst_count", 32'(bus.count), 32'd3);
    check("sticky_overflow", 32'(bus.overflow), 32'd1);
    check("sticky_underflow", 32'(bus.underflow), 32'd1);

    rst = 1'b1;
    step(1'b1, 8'h77, 1'b1);
    rst = 1'b0;
    check("midrst_count", 32'(bus.count), 32'd0);
    check("midrst_empty", 32'(bus.empty), 32'd1);
    check("midrst_readdata", 32'(bus.readdata), 32'h00);
    check("midrst_overflow", 32'(bus.overflow), 32'd0);
    check("midrst_underflow", 32'(bus.underflow), 32'd0);
    check("midrst_valid", 32'(bus.readvalid), 32'd0);

    step(1'b1, 8'h9C, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    check("post_rst_read", 32'(bus.readdata), 32'h9C);
    check("post_rst_empty", 32'(bus.empty), 32'd1);

`ifdef WRITE_SINK_XCHECK_EN
    check("xerr_reset", 32'(xerr), 32'd0);
    bus.write_enable = 1'b0;
    bus.writedata    = 'x;
    bus.read_enable  = 1'b0;
    @(posedge clk);
    #1;
    check("xerr_idle_x", 32'(xerr), 32'd0);
    check("xerr_idle_count", 32'(bus.count), 32'd0);
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
    bus.writedata    = 8'h00;
    check("xerr_set", 32'(xerr), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
